// File: rtl/mem_access_if.sv
// Request/response handshake bundle between a requester and mem_access_unit.
interface mem_access_if #(parameter int ADDR_W = 14) ();
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic              req_byte;
  logic [ADDR_W-1:0] req_addr;
  logic [15:0]       req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [15:0]       rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_byte, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_byte, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store unit for a 16-bit memory whose word at A is {byte[A], byte[A-1]}.
// Byte stores are done as read-modify-write so byte A-1 is preserved.
module mem_access_unit #(
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              rst,
  mem_access_if.slave       bus,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_data_in,
  output logic              mem_we,
  input  logic [15:0]       mem_data_out
);

  typedef enum logic [2:0] {IDLE, RD, SETUP, WR, RESP} state_t;

  state_t      state;
  state_t      next_state;
  logic        accept;
  logic        addr_zero;
  logic        we_q;
  logic        byte_q;
  logic [7:0]  wdata_lo_q;
  logic [15:0] rdata_q;
  logic        err_q;

  assign addr_zero     = (bus.req_addr == '0);
  assign bus.req_ready = (state == IDLE) && !rst;
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          accept = 1'b1;
          // Address 0 is rejected because byte A-1 would wrap around.
          if (addr_zero)                         next_state = RESP;
          else if (!bus.req_we || bus.req_byte)  next_state = RD;
          else                                   next_state = SETUP;
        end
      end
      RD:      next_state = we_q ? SETUP : RESP;
      SETUP:   next_state = WR;
      WR:      next_state = RESP;
      RESP:    if (bus.rsp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we_q        <= 1'b0;
      byte_q      <= 1'b0;
      wdata_lo_q  <= 8'h00;
      mem_addr    <= '0;
      mem_data_in <= 16'h0000;
      mem_we      <= 1'b0;
      rdata_q     <= 16'h0000;
      err_q       <= 1'b0;
    end else begin
      // Registered write strobe: high exactly during WR, which always follows SETUP.
      mem_we <= (state == SETUP);
      case (state)
        IDLE: begin
          if (accept) begin
            we_q       <= bus.req_we;
            byte_q     <= bus.req_byte;
            wdata_lo_q <= bus.req_wdata[7:0];
            mem_addr   <= bus.req_addr;
            rdata_q    <= 16'h0000;
            err_q      <= addr_zero;
            if (bus.req_we && !bus.req_byte && !addr_zero)
              mem_data_in <= bus.req_wdata;
          end
        end
        RD: begin
          if (we_q)
            mem_data_in <= {wdata_lo_q, mem_data_out[7:0]};
          else
            rdata_q <= byte_q ? {8'h00, mem_data_out[15:8]} : mem_data_out;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rdata_q <= 16'h0000;
            err_q   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
